// File: rtl/branch_predictor.sv
`timescale 1ns/1ps
// gshare conditional-branch direction predictor for the IF stage.
// Trains on resolved EX outcomes, flags mispredicts, and counts branch/mispredict events.
module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int GHR_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pred_valid,
    input  logic [31:0]         pred_pc,
    output logic                pred_taken,
    output logic [IDX_BITS-1:0] pred_idx,
    input  logic                upd_valid,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_br_en,
    input  logic                upd_pred_taken,
    output logic                mispredict,
    output logic [31:0]         br_count,
    output logic [31:0]         mispred_count
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0]          pht [ENTRIES];
    logic [GHR_BITS-1:0] ghr;
    logic [IDX_BITS-1:0] ghr_ext;
    logic [GHR_BITS:0]   ghr_shift;
    logic [1:0]          upd_cur;
    logic [1:0]          upd_nxt;
    logic [31:0]         br_cnt_q;
    logic [31:0]         mis_cnt_q;
    logic                unused_bits;

    // History is narrower than or equal to the index; zero-extend before hashing.
    assign ghr_ext    = IDX_BITS'(ghr);
    assign pred_idx   = pred_pc[IDX_BITS+1:2] ^ ghr_ext;
    assign pred_taken = pht[pred_idx][1];

    assign mispredict = upd_valid & (upd_br_en ^ upd_pred_taken);

    assign upd_cur   = pht[upd_idx];
    assign ghr_shift = {ghr, upd_br_en};

    always_comb begin
        upd_nxt = upd_cur;
        if (upd_br_en) begin
            if (upd_cur != 2'b11) begin
                upd_nxt = upd_cur + 2'b01;
            end
        end else begin
            if (upd_cur != 2'b00) begin
                upd_nxt = upd_cur - 2'b01;
            end
        end
    end

    // Pattern table: every entry resets to weakly not-taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht[i] <= 2'b01;
            end
        end else if (upd_valid) begin
            pht[upd_idx] <= upd_nxt;
        end
    end

    // Non-speculative history: only resolved outcomes shift in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr <= '0;
        end else if (upd_valid) begin
            ghr <= ghr_shift[GHR_BITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else if (upd_valid) begin
            br_cnt_q <= br_cnt_q + 32'd1;
            if (mispredict) begin
                mis_cnt_q <= mis_cnt_q + 32'd1;
            end
        end
    end

    assign br_count      = br_cnt_q;
    assign mispred_count = mis_cnt_q;

    // pred_valid only qualifies the outputs downstream; the PC byte offset and upper bits never index.
    assign unused_bits = ^{pred_valid, pred_pc[31:IDX_BITS+2], pred_pc[1:0], ghr_shift[GHR_BITS]};

endmodule

// File: tb/tb_branch_predictor.sv
`timescale 1ns/1ps
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// compared against an array-based behavioural model.
module tb_branch_predictor;

    localparam int IDX_BITS = 6;
    localparam int GHR_BITS = 6;
    localparam int ENTRIES  = 64;

    logic        clk;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [5:0]  pred_idx;
    logic        upd_valid;
    logic [5:0]  upd_idx;
    logic        upd_br_en;
    logic        upd_pred_taken;
    logic        mispredict;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int checks;
    int errors;

    // Behavioural model
    int          m_pht [ENTRIES];
    int          m_ghr;
    logic [31:0] m_br;
    logic [31:0] m_mis;

    branch_predictor #(.IDX_BITS(IDX_BITS), .GHR_BITS(GHR_BITS)) dut (
        .clk            (clk),
        .rst            (rst),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .pred_idx       (pred_idx),
        .upd_valid      (upd_valid),
        .upd_idx        (upd_idx),
        .upd_br_en      (upd_br_en),
        .upd_pred_taken (upd_pred_taken),
        .mispredict     (mispredict),
        .br_count       (br_count),
        .mispred_count  (mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void mdl_reset();
        for (int i = 0; i < ENTRIES; i++) m_pht[i] = 1;
        m_ghr = 0;
        m_br  = 0;
        m_mis = 0;
    endfunction

    function automatic int mdl_idx(input logic [31:0] pc);
        return ((pc >> 2) % ENTRIES) ^ m_ghr;
    endfunction

    function automatic logic [31:0] pc_for(input int entry);
        return 32'((entry ^ m_ghr) * 4);
    endfunction

    function automatic void mdl_update();
        int e;
        e = int'(upd_idx);
        if (upd_br_en) m_pht[e] = (m_pht[e] == 3) ? 3 : m_pht[e] + 1;
        else           m_pht[e] = (m_pht[e] == 0) ? 0 : m_pht[e] - 1;
        m_ghr = ((m_ghr * 2) + int'(upd_br_en)) % (1 << GHR_BITS);
        m_br  = m_br + 1;
        if (upd_br_en != upd_pred_taken) m_mis = m_mis + 1;
    endfunction

    // Compare all outputs with the model; called away from the clock edge.
    task automatic chk_all(input string tag);
        int ei;
        ei = mdl_idx(pred_pc);
        chk({tag, ".idx"},   32'(pred_idx),   32'(ei));
        chk({tag, ".taken"}, 32'(pred_taken), 32'(m_pht[ei] >= 2));
        chk({tag, ".mis"},   32'(mispredict), 32'(upd_valid && (upd_br_en != upd_pred_taken)));
        chk({tag, ".brc"},   br_count,        m_br);
        chk({tag, ".misc"},  mispred_count,   m_mis);
    endtask

    task automatic tick();
        @(posedge clk);
        if (upd_valid) mdl_update();
        @(negedge clk);
    endtask

    task automatic drive_upd(input logic v, input int idx, input logic br, input logic pt);
        upd_valid      = v;
        upd_idx        = 6'(idx);
        upd_br_en      = br;
        upd_pred_taken = pt;
    endtask

    task automatic read_entry(input string tag, input int entry);
        pred_pc = pc_for(entry);
        #1;
        chk(tag, 32'(pred_taken), 32'(m_pht[entry] >= 2));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        pred_valid = 1'b1;
        pred_pc = 32'h0000_0040;
        drive_upd(1'b0, 0, 1'b0, 1'b0);
        mdl_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;

        // Reset state
        chk("rst_idx",   32'(pred_idx),   32'h10);
        chk("rst_taken", 32'(pred_taken), 32'h0);
        chk("rst_brc",   br_count,        32'h0);
        chk("rst_misc",  mispred_count,   32'h0);

        // Two taken updates on entry 0x10 predicted not-taken
        for (int k = 0; k < 2; k++) begin
            drive_upd(1'b1, 'h10, 1'b1, 1'b0);
            #1;
            chk("train_mis", 32'(mispredict), 32'h1);
            tick();
        end
        drive_upd(1'b0, 0, 1'b0, 1'b0);
        pred_pc = 32'h0000_0040;
        #1;
        chk("train_idx",  32'(pred_idx),   32'h13);
        chk("train_brc",  br_count,        32'h2);
        chk("train_misc", mispred_count,   32'h2);
        chk_all("train");
        read_entry("train_e10", 'h10);
        chk("train_e10_T", 32'(pred_taken), 32'h1);

        // Saturation on entry 0x05
        for (int k = 0; k < 4; k++) begin
            drive_upd(1'b1, 'h05, 1'b1, 1'b1);
            tick();
        end
        drive_upd(1'b0, 0, 1'b0, 1'b0);
        read_entry("sat_hi", 'h05);
        chk("sat_hi_T", 32'(pred_taken), 32'h1);
        chk("sat_hi_mdl", 32'(m_pht['h05]), 32'h3);
        for (int k = 0; k < 4; k++) begin
            drive_upd(1'b1, 'h05, 1'b0, 1'b1);
            tick();
        end
        drive_upd(1'b0, 0, 1'b0, 1'b0);
        read_entry("sat_lo", 'h05);
        drive_upd(1'b1, 'h05, 1'b0, 1'b0);
        tick();
        drive_upd(1'b0, 0, 1'b0, 1'b0);
        read_entry("sat_hold", 'h05);
        chk("sat_hold_NT", 32'(pred_taken), 32'h0);
        // One more taken must lift it only to weak NT, proving it held at 00.
        drive_upd(1'b1, 'h05, 1'b1, 1'b0);
        tick();
        drive_upd(1'b0, 0, 1'b0, 1'b0);
        read_entry("sat_weak", 'h05);
        chk("sat_weak_NT", 32'(pred_taken), 32'h0);

        // Same-cycle read and update of entry 0x07: no bypass
        pred_pc = pc_for('h07);
        drive_upd(1'b1, 'h07, 1'b1, 1'b0);
        #1;
        chk("same_pre",  32'(pred_taken), 32'h0);
        chk("same_idx",  32'(pred_idx),   32'h07);
        tick();
        drive_upd(1'b0, 0, 1'b0, 1'b0);
        read_entry("same_post", 'h07);
        chk("same_post_T", 32'(pred_taken), 32'h1);
        chk_all("same");

        // br_count wrap
        force dut.br_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.br_cnt_q;
        m_br = 32'hFFFF_FFFF;
        #1;
        chk("wrap_pre", br_count, 32'hFFFF_FFFF);
        drive_upd(1'b1, 'h20, 1'b0, 1'b0);
        tick();
        drive_upd(1'b0, 0, 1'b0, 1'b0);
        #1;
        chk("wrap_brc", br_count, 32'h0);
        chk_all("wrap");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            pred_pc    = $urandom();
            pred_valid = 1'($urandom_range(0, 1));
            drive_upd(($urandom_range(0, 3) != 0), int'($urandom_range(0, ENTRIES - 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            #1;
            chk_all("rand");
            tick();
        end

        // Asynchronous reset mid-cycle while an update is pending
        pred_pc = 32'h0000_0040;
        drive_upd(1'b1, 'h10, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        mdl_reset();
        #1;
        chk("arst_brc",  br_count,         32'h0);
        chk("arst_misc", mispred_count,    32'h0);
        chk("arst_idx",  32'(pred_idx),    32'h10);
        chk("arst_taken", 32'(pred_taken), 32'h0);
        chk("arst_mis",  32'(mispredict),  32'h1);
        for (int e = 0; e < ENTRIES; e += 5) begin
            pred_pc = 32'(e * 4);
            #1;
            chk("arst_entry", 32'(pred_taken), 32'h0);
        end
        @(posedge clk);
        #1;
        chk("arst_hold_brc", br_count, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive_upd(1'b0, 0, 1'b0, 1'b0);
        pred_pc = 32'h0000_0040;
        #1;
        chk_all("arst_after");
        read_entry("arst_e10", 'h10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- gshare direction predictor for the 5-stage RV32I pipeline.
- Sits in IF: predicts conditional-branch direction from the fetch PC.
- Consumes the resolved branch outcome (comparator br_en) from EX: trains its 2-bit counters and flags mispredicts to the hazard/flush logic.
- Also keeps branch and mispredict event counters for performance readout.

Parameters:
- IDX_BITS, 6, log2 of pattern-table entries (64 two-bit counters).
- GHR_BITS, 6, global history length in bits; must be <= IDX_BITS.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pred_valid  in  1  IF holds a conditional branch needing a prediction.
- pred_pc  in  32  IF-stage PC.
- pred_taken  out  1  predicted direction, combinational, same cycle.
- pred_idx  out  IDX_BITS  table index used; piped to EX with the instruction.
- upd_valid  in  1  EX resolves a conditional branch this cycle; qualified by pipeline not stalled.
- upd_idx  in  IDX_BITS  pred_idx carried with the resolving branch.
- upd_br_en  in  1  actual outcome from comparator (1 = taken).
- upd_pred_taken  in  1  prediction carried with the resolving branch.
- mispredict  out  1  combinational: upd_valid & (upd_br_en != upd_pred_taken).
- br_count  out  32  resolved conditional branches since reset.
- mispred_count  out  32  mispredicts since reset.

Behaviour:
- Storage: 2^IDX_BITS x 2-bit saturating counters (flops), plus a GHR_BITS global history register (ghr), plus the two 32-bit counters.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Reset (rst low, asynchronous, any time including mid-update):
  - every counter <= 01
  - ghr <= 0
  - br_count and mispred_count <= 0
  - while rst is low: pred_taken follows table (0), mispredict is still combinational from inputs.
- Index: pred_idx = pred_pc[IDX_BITS+1:2] XOR {zero-extend ghr to IDX_BITS}. pred_pc[1:0] is ignored.
- Prediction: pred_taken = table[pred_idx][1]. Pure read, zero latency, no state change.
  - When pred_valid = 0, pred_taken and pred_idx are still driven from pred_pc; downstream ignores them.
- Update, on a clock edge with upd_valid = 1:
  - upd_br_en = 1: table[upd_idx] increments, saturating at 11.
  - upd_br_en = 0: table[upd_idx] decrements, saturating at 00.
  - ghr <= {ghr[GHR_BITS-2:0], upd_br_en}. History is non-speculative; only resolved outcomes shift in.
  - br_count += 1, wrapping 0xFFFFFFFF -> 0.
  - If mispredict: mispred_count += 1, same wrap rule.
- upd_valid = 0: no state change.
- Simultaneous read and update of the same index in one cycle: the read returns the pre-update value (no bypass). pred_idx in that cycle uses the pre-shift ghr.
- Update to upd_idx affects only that entry; all others hold.
- Exactly one update per cycle maximum; the pipeline guarantees this.
- mispredict has no registered copy. The flush/redirect in the same cycle is owned by the hazard unit.

Test Plan:
- Reset, then pred_pc=0x00000040, ghr=0 -> pred_idx=0x10, pred_taken=0; br_count=0, mispred_count=0.
- Two updates upd_idx=0x10, upd_br_en=1, upd_pred_taken=0 -> entry goes 01->10->11; mispredict=1 both cycles; mispred_count=2, br_count=2; ghr=0b000011. Then pred_pc=0x40 -> pred_idx=0x13.
- Saturation:
  - entry 0x05: four taken updates -> stays 11, pred_taken=1.
  - then four not-taken updates -> 00.
  - a fifth not-taken update -> holds 00, pred_taken=0.
- Same cycle: read idx 0x07 (value 01) while updating idx 0x07 taken -> pred_taken=0 that cycle, 1 the next cycle.
- Preload br_count=0xFFFFFFFF (force or long run), one update -> br_count=0x00000000.
- Assert rst low asynchronously mid-cycle during upd_valid=1 -> all entries 01, ghr=0, counters 0 immediately, without waiting for clk. The update is lost.
